// File: rtl/alu_ex_pipe_if.sv
// Valid/ready bundle for the EX-stage ALU: operation in, tagged result out.
// master drives operations and downstream ready; slave is the ALU.
interface alu_ex_pipe_if #(
  parameter int TAG_W = 5
);
  logic             i_valid;
  logic             o_ready;
  logic [3:0]       i_op;
  logic [31:0]      i_a;
  logic [31:0]      i_b;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [31:0]      o_result;
  logic [TAG_W-1:0] o_tag;
  logic             o_illegal;

  modport master (
    output i_valid, i_op, i_a, i_b, i_tag, i_ready,
    input  o_ready, o_valid, o_result, o_tag, o_illegal
  );

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_tag, i_ready,
    output o_ready, o_valid, o_result, o_tag, o_illegal
  );
endinterface

// File: rtl/alu_ex_pipe.sv
// Two-stage RV32I execute ALU: S1 operand register, S2 result register,
// elastic valid/ready handshake with full throughput and backpressure.
module alu_barrel #(
  parameter bit LEFT  = 1'b0,
  parameter bit ARITH = 1'b0
) (
  input  logic [31:0] i_d,
  input  logic [4:0]  i_sh,
  output logic [31:0] o_d
);
  logic        fill;
  logic [31:0] st;

  assign fill = ARITH & i_d[31];

  always_comb begin
    st = i_d;
    for (int k = 0; k < 5; k++) begin
      if (i_sh[k]) begin
        if (LEFT) begin
          st = st << (2 ** k);
        end else begin
          st = ({32{fill}} << (32 - 2 ** k))
             | (st >> (2 ** k));
        end
      end
    end
  end

  assign o_d = st;
endmodule

module alu_addsub (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  output logic [31:0] o_sum
);
  logic [31:0] b_x;

  assign b_x   = i_b ^ {32{i_sub}};
  assign o_sum = i_a + b_x + {31'b0, i_sub};
endmodule

module alu_cmp (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_lt_s,
  output logic        o_lt_u
);
  assign o_lt_s = $signed(i_a) < $signed(i_b);
  assign o_lt_u = i_a < i_b;
endmodule

module alu_ex_pipe #(
  parameter int TAG_W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  alu_ex_pipe_if.slave bus
);
  typedef struct packed {
    logic [3:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } s2_t;

  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_adv, s2_adv;

  assign s2_adv      = !s2_valid_q | bus.i_ready;
  assign s1_adv      = !s1_valid_q | s2_adv;
  assign bus.o_ready = s1_adv;

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (s1_adv) begin
      s1_valid_d = bus.i_valid;
      if (bus.i_valid) begin
        s1_d = '{op:  bus.i_op,
                 a:   bus.i_a,
                 b:   bus.i_b,
                 tag: bus.i_tag};
      end
    end
  end

  logic is_add, is_sub, is_sll, is_slt;
  logic is_sltu, is_xor, is_srl, is_sra;
  logic is_or, is_and;

  assign is_add  = s1_q.op == 4'b0000;
  assign is_sub  = s1_q.op == 4'b1000;
  assign is_sll  = s1_q.op == 4'b0001;
  assign is_slt  = s1_q.op == 4'b0010;
  assign is_sltu = s1_q.op == 4'b0011;
  assign is_xor  = s1_q.op == 4'b0100;
  assign is_srl  = s1_q.op == 4'b0101;
  assign is_sra  = s1_q.op == 4'b1101;
  assign is_or   = s1_q.op == 4'b0110;
  assign is_and  = s1_q.op == 4'b0111;

  logic [31:0] sum, sll_r, srl_r, sra_r;
  logic        lt_s, lt_u;

  alu_addsub u_addsub (
    .i_a   (s1_q.a),
    .i_b   (s1_q.b),
    .i_sub (is_sub),
    .o_sum (sum)
  );

  alu_cmp u_cmp (
    .i_a    (s1_q.a),
    .i_b    (s1_q.b),
    .o_lt_s (lt_s),
    .o_lt_u (lt_u)
  );

  alu_barrel #(.LEFT(1'b1), .ARITH(1'b0)) u_sll (
    .i_d  (s1_q.a),
    .i_sh (s1_q.b[4:0]),
    .o_d  (sll_r)
  );

  alu_barrel #(.LEFT(1'b0), .ARITH(1'b0)) u_srl (
    .i_d  (s1_q.a),
    .i_sh (s1_q.b[4:0]),
    .o_d  (srl_r)
  );

  alu_barrel #(.LEFT(1'b0), .ARITH(1'b1)) u_sra (
    .i_d  (s1_q.a),
    .i_sh (s1_q.b[4:0]),
    .o_d  (sra_r)
  );

  logic [31:0] alu_res;
  logic        alu_ill;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    unique case (1'b1)
      is_add,
      is_sub:  alu_res = sum;
      is_sll:  alu_res = sll_r;
      is_slt:  alu_res = {31'b0, lt_s};
      is_sltu: alu_res = {31'b0, lt_u};
      is_xor:  alu_res = s1_q.a ^ s1_q.b;
      is_srl:  alu_res = srl_r;
      is_sra:  alu_res = sra_r;
      is_or:   alu_res = s1_q.a | s1_q.b;
      is_and:  alu_res = s1_q.a & s1_q.b;
      default: alu_ill = 1'b1;
    endcase
  end

  // Result data only moves on a real op, so bubbles never disturb it.
  always_comb begin
    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d = '{res: alu_res,
                 tag: s1_q.tag,
                 ill: alu_ill};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_q       <= s2_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign bus.o_valid   = s2_valid_q;
  assign bus.o_result  = s2_q.res;
  assign bus.o_tag     = s2_q.tag;
  assign bus.o_illegal = s2_q.ill;
endmodule

// File: tb/tb_alu_ex_pipe.sv
// Bench for alu_ex_pipe: directed cases plus random traffic
// checked against an in-order queue of expected results.
module tb_alu_ex_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_ex_pipe_if #(.TAG_W(5)) ifc ();

  alu_ex_pipe #(.TAG_W(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifc.slave)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  logic [4:0]  got[$];
  int          total  = 0;
  int          passed = 0;
  logic        in_f, out_f;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_res = '0;
  logic [4:0]  prev_tag = '0;

  task automatic chk(string name, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", name, obs, expv);
  endtask

  function automatic exp_t model(logic [3:0] op, logic [31:0] a,
                                 logic [31:0] b, logic [4:0] tag);
    exp_t e;
    int   sh;
    sh    = int'(b % 32);
    e.tag = tag;
    e.ill = 1'b0;
    e.res = '0;
    case (op)
      4'd0:  e.res = a + b;
      4'd8:  e.res = a - b;
      4'd1:  e.res = a << sh;
      4'd2:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  e.res = (a < b) ? 32'd1 : 32'd0;
      4'd4:  e.res = a ^ b;
      4'd5:  e.res = a >> sh;
      4'd13: e.res = $signed(a) >>> sh;
      4'd6:  e.res = a | b;
      4'd7:  e.res = a & b;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic cycle();
    @(negedge clk);
    in_f  = ifc.i_valid & ifc.o_ready;
    out_f = ifc.o_valid & ifc.i_ready;
    if (stall_prev) begin
      chk("stall_result", ifc.o_result, prev_res);
      chk("stall_tag", 32'(ifc.o_tag), 32'(prev_tag));
    end
    if (ifc.o_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 32'(ifc.o_valid), 32'd0);
      end else begin
        chk("result", ifc.o_result, q[0].res);
        chk("tag", 32'(ifc.o_tag), 32'(q[0].tag));
        chk("illegal", 32'(ifc.o_illegal), 32'(q[0].ill));
      end
    end
    stall_prev = ifc.o_valid & !ifc.i_ready;
    prev_res   = ifc.o_result;
    prev_tag   = ifc.o_tag;
    if (out_f) begin
      got.push_back(ifc.o_tag);
      if (q.size() != 0) void'(q.pop_front());
    end
    if (in_f) q.push_back(model(ifc.i_op, ifc.i_a, ifc.i_b, ifc.i_tag));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [3:0] op, logic [31:0] a,
                       logic [31:0] b, logic [4:0] tag);
    ifc.i_valid = 1'b1;
    ifc.i_op    = op;
    ifc.i_a     = a;
    ifc.i_b     = b;
    ifc.i_tag   = tag;
  endtask

  task automatic send(logic [3:0] op, logic [31:0] a,
                      logic [31:0] b, logic [4:0] tag);
    drive(op, a, b, tag);
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (in_f) break;
    end
    if (!in_f) chk("send_timeout", 32'd0, 32'd1);
    ifc.i_valid = 1'b0;
  endtask

  task automatic wait_out(string name, logic [31:0] res,
                          logic ill, logic [4:0] tag);
    for (int n = 0; n < 20; n++) begin
      if (ifc.o_valid) break;
      cycle();
    end
    chk({name, "_valid"}, 32'(ifc.o_valid), 32'd1);
    chk({name, "_res"}, ifc.o_result, res);
    chk({name, "_ill"}, 32'(ifc.o_illegal), 32'(ill));
    chk({name, "_tag"}, 32'(ifc.o_tag), 32'(tag));
  endtask

  logic [3:0] ops [12];

  initial begin
    ops = '{4'd0, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd13, 4'd6, 4'd7, 4'd15, 4'd9};
    ifc.i_valid = 1'b0;
    ifc.i_ready = 1'b1;
    ifc.i_op    = '0;
    ifc.i_a     = '0;
    ifc.i_b     = '0;
    ifc.i_tag   = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ifc.o_valid), 32'd0);
    chk("rst_result", ifc.o_result, 32'd0);
    chk("rst_tag", 32'(ifc.o_tag), 32'd0);
    chk("rst_illegal", 32'(ifc.o_illegal), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(ifc.o_ready), 32'd1);

    send(4'd13, 32'h8000_0000, 32'h4, 5'd3);
    chk("lat_first_edge", 32'(ifc.o_valid), 32'd0);
    cycle();
    chk("lat_second_edge", 32'(ifc.o_valid), 32'd1);
    wait_out("sra", 32'hF800_0000, 1'b0, 5'd3);

    send(4'd1, 32'h1, 32'h21, 5'd4);
    wait_out("sll_mask", 32'h2, 1'b0, 5'd4);
    send(4'd5, 32'h8000_0000, 32'd31, 5'd5);
    wait_out("srl31", 32'h1, 1'b0, 5'd5);

    send(4'd2, 32'hFFFF_FFFF, 32'h1, 5'd6);
    wait_out("slt", 32'h1, 1'b0, 5'd6);
    send(4'd3, 32'hFFFF_FFFF, 32'h1, 5'd7);
    wait_out("sltu", 32'h0, 1'b0, 5'd7);
    send(4'd8, 32'h0, 32'h1, 5'd8);
    wait_out("sub", 32'hFFFF_FFFF, 1'b0, 5'd8);
    send(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd9);
    wait_out("add_wrap", 32'h0, 1'b0, 5'd9);

    send(4'd15, 32'd5, 32'd7, 5'd10);
    wait_out("illegal", 32'h0, 1'b1, 5'd10);
    send(4'd0, 32'd5, 32'd7, 5'd11);
    wait_out("after_illegal", 32'd12, 1'b0, 5'd11);
    cycle();

    got.delete();
    send(4'd0, 32'd10, 32'd20, 5'd0);
    wait_out("bp0", 32'd30, 1'b0, 5'd0);
    ifc.i_ready = 1'b0;
    drive(4'd4, 32'hA5A5_0000, 32'h0000_5A5A, 5'd1);
    #1;
    chk("s2_only_ready", 32'(ifc.o_ready), 32'd1);
    cycle();
    chk("s2_only_accept", 32'(in_f), 32'd1);
    drive(4'd6, 32'h0F00, 32'h00F0, 5'd2);
    #1;
    chk("full_stall_ready", 32'(ifc.o_ready), 32'd0);
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("full_stall_noaccept", 32'(in_f), 32'd0);
      chk("full_stall_oready", 32'(ifc.o_ready), 32'd0);
    end
    ifc.i_ready = 1'b1;
    #1;
    chk("drain_fill_ready", 32'(ifc.o_ready), 32'd1);
    cycle();
    chk("drain_fill_accept", 32'(in_f), 32'd1);
    chk("drain_fill_drain", 32'(out_f), 32'd1);
    send(4'd7, 32'hFFFF_00FF, 32'h0F0F_0F0F, 5'd3);
    for (int n = 0; n < 20 && q.size() != 0; n++) cycle();
    chk("bp_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("bp_order", 32'(got[i]), 32'(i));

    ifc.i_ready = 1'b0;
    drive(4'd4, 32'hF0, 32'h0F, 5'd7);
    cycle();
    drive(4'd0, 32'd1, 32'd2, 5'd8);
    cycle();
    ifc.i_valid = 1'b0;
    chk("pre_rst_valid", 32'(ifc.o_valid), 32'd1);
    chk("pre_rst_full", 32'(ifc.o_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(ifc.o_valid), 32'd0);
    chk("async_rst_result", ifc.o_result, 32'd0);
    chk("async_rst_tag", 32'(ifc.o_tag), 32'd0);
    chk("async_rst_ill", 32'(ifc.o_illegal), 32'd0);
    q.delete();
    stall_prev  = 1'b0;
    ifc.i_ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(ifc.o_ready), 32'd1);
    for (int n = 0; n < 4; n++) begin
      cycle();
      chk("post_rst_no_stale", 32'(ifc.o_valid), 32'd0);
    end

    got.delete();
    for (int n = 0; n < 400; n++) begin
      ifc.i_valid = ($urandom_range(0, 3) != 0);
      ifc.i_ready = ($urandom_range(0, 3) != 0);
      ifc.i_op    = ops[$urandom_range(0, 11)];
      ifc.i_a     = $urandom;
      ifc.i_b     = ($urandom_range(0, 1) != 0) ? $urandom
                                                : 32'($urandom_range(0, 40));
      ifc.i_tag   = 5'($urandom_range(0, 31));
      cycle();
    end
    ifc.i_valid = 1'b0;
    ifc.i_ready = 1'b1;
    for (int n = 0; n < 20 && q.size() != 0; n++) cycle();
    chk("final_drain", 32'(q.size()), 32'd0);
    cycle();
    chk("final_idle", 32'(ifc.o_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
